// File: rtl/toggle_reduce_bank.sv
// toggle_reduce_bank
//   A bank of NUM_CH toggle flops. Contiguous groups of GROUP channels are
//   reduced into NUM_OUT registered outputs under an 8-mode select, one of
//   which is HOLD. Each output has a saturating transition counter, and a
//   snapshot handshake reads all of the counters at once.
//
// Ports
//   clk       in   clock; all state updates on posedge
//   clr       in   synchronous active-high reset; overrides every other input
//   t         in   [NUM_CH]      per-channel toggle enable
//   sel       in   [3]           reduction mode (XOR AND OR 0 XNOR NAND NOR HOLD)
//   snap_req  in   snapshot request, sampled on each posedge
//   q         out  [NUM_CH]      toggle flop states
//   mux_out   out  [NUM_OUT]     registered reduction results
//   snap_ack  out  one-cycle snapshot acknowledge
//   snap_cnt  out  [NUM_OUT*CNT_W] captured counters; output j is in [j*CNT_W +: CNT_W]
//
// Snapshot handshake: snap_req acts as a request with no ready qualifier, so
// every posedge that samples it high performs one snapshot. snap_ack is high
// for exactly the cycle after each sampled request. snap_cnt is valid while
// snap_ack is high and holds until the next snapshot or clr.
module toggle_reduce_bank #(
  parameter int NUM_CH = 80,
  parameter int GROUP  = 4,
  parameter int CNT_W  = 8,
  localparam int NUM_OUT = NUM_CH / GROUP
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_CH-1:0]        t,
  input  logic [2:0]               sel,
  input  logic                     snap_req,
  output logic [NUM_CH-1:0]        q,
  output logic [NUM_OUT-1:0]       mux_out,
  output logic                     snap_ack,
  output logic [NUM_OUT*CNT_W-1:0] snap_cnt
);

  localparam logic [2:0] SEL_XOR  = 3'd0;
  localparam logic [2:0] SEL_AND  = 3'd1;
  localparam logic [2:0] SEL_OR   = 3'd2;
  localparam logic [2:0] SEL_ZERO = 3'd3;
  localparam logic [2:0] SEL_XNOR = 3'd4;
  localparam logic [2:0] SEL_NAND = 3'd5;
  localparam logic [2:0] SEL_NOR  = 3'd6;
  localparam logic [2:0] SEL_HOLD = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0]        q_q, q_d;
  logic [NUM_OUT-1:0]       mux_q, mux_d;
  logic [NUM_OUT*CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_OUT*CNT_W-1:0] snap_cnt_q, snap_cnt_d;
  logic                     snap_ack_q, snap_ack_d;

  logic             red_xor, red_and, red_or;
  logic [CNT_W-1:0] cand;

  always_comb begin
    q_d        = q_q ^ t;
    mux_d      = mux_q;
    cnt_d      = cnt_q;
    snap_cnt_d = snap_cnt_q;
    snap_ack_d = snap_req;
    red_xor    = 1'b0;
    red_and    = 1'b0;
    red_or     = 1'b0;
    cand       = '0;

    for (int j = 0; j < NUM_OUT; j++) begin
      // The reductions use the current q, so mux_out lags q by one edge.
      red_xor = ^q_q[j*GROUP +: GROUP];
      red_and = &q_q[j*GROUP +: GROUP];
      red_or  = |q_q[j*GROUP +: GROUP];

      case (sel)
        SEL_XOR:  mux_d[j] = red_xor;
        SEL_AND:  mux_d[j] = red_and;
        SEL_OR:   mux_d[j] = red_or;
        SEL_ZERO: mux_d[j] = 1'b0;
        SEL_XNOR: mux_d[j] = ~red_xor;
        SEL_NAND: mux_d[j] = ~red_and;
        SEL_NOR:  mux_d[j] = ~red_or;
        SEL_HOLD: mux_d[j] = mux_q[j];
        default:  mux_d[j] = mux_q[j];
      endcase

      // The candidate count includes this edge's transition, saturating at max.
      cand = cnt_q[j*CNT_W +: CNT_W];
      if ((mux_d[j] != mux_q[j]) && (cand != CNT_MAX)) begin
        cand = cand + CNT_ONE;
      end

      // A snapshot captures the candidate and restarts the live count from zero.
      if (snap_req) begin
        snap_cnt_d[j*CNT_W +: CNT_W] = cand;
        cnt_d[j*CNT_W +: CNT_W]      = '0;
      end else begin
        cnt_d[j*CNT_W +: CNT_W]      = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q        <= '0;
      mux_q      <= '0;
      cnt_q      <= '0;
      snap_cnt_q <= '0;
      snap_ack_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      mux_q      <= mux_d;
      cnt_q      <= cnt_d;
      snap_cnt_q <= snap_cnt_d;
      snap_ack_q <= snap_ack_d;
    end
  end

  assign q        = q_q;
  assign mux_out  = mux_q;
  assign snap_ack = snap_ack_q;
  assign snap_cnt = snap_cnt_q;

endmodule

// File: tb/tb_toggle_reduce_bank.sv
module tb_toggle_reduce_bank;

  localparam int NUM_CH  = 80;
  localparam int GROUP   = 4;
  localparam int CNT_W   = 4;
  localparam int NUM_OUT = NUM_CH / GROUP;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int SW      = NUM_OUT * CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clr = 1'b1;
  logic [NUM_CH-1:0] t = '0;
  logic [2:0]        sel = 3'd0;
  logic              snap_req = 1'b0;
  logic [NUM_CH-1:0]  q;
  logic [NUM_OUT-1:0] mux_out;
  logic               snap_ack;
  logic [SW-1:0]      snap_cnt;

  toggle_reduce_bank #(.NUM_CH(NUM_CH), .GROUP(GROUP), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .t(t), .sel(sel), .snap_req(snap_req),
    .q(q), .mux_out(mux_out), .snap_ack(snap_ack), .snap_cnt(snap_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_q   [NUM_CH];
  bit m_mux [NUM_OUT];
  int m_cnt [NUM_OUT];
  int m_snap[NUM_OUT];
  bit m_ack;
  logic [SW-1:0] exp_q[$];

  task automatic model_step();
    int ones;
    bit nxt;
    int cand;
    logic [SW-1:0] cap;
    if (clr) begin
      foreach (m_q[i]) m_q[i] = 0;
      for (int j = 0; j < NUM_OUT; j++) begin
        m_mux[j] = 0; m_cnt[j] = 0; m_snap[j] = 0;
      end
      m_ack = 0;
      exp_q.delete();
      return;
    end
    cap = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      ones = 0;
      for (int k = 0; k < GROUP; k++) ones += int'(m_q[j*GROUP + k]);
      case (sel)
        3'd0: nxt = (ones % 2) == 1;
        3'd1: nxt = ones == GROUP;
        3'd2: nxt = ones > 0;
        3'd3: nxt = 0;
        3'd4: nxt = (ones % 2) == 0;
        3'd5: nxt = ones != GROUP;
        3'd6: nxt = ones == 0;
        default: nxt = m_mux[j];
      endcase
      cand = m_cnt[j];
      if (nxt != m_mux[j] && cand < CMAX) cand++;
      if (snap_req) begin
        m_snap[j] = cand;
        m_cnt[j] = 0;
        cap[j*CNT_W +: CNT_W] = CNT_W'(cand);
      end else begin
        m_cnt[j] = cand;
      end
      m_mux[j] = nxt;
    end
    if (snap_req) exp_q.push_back(cap);
    m_ack = snap_req;
    foreach (m_q[i]) m_q[i] = m_q[i] ^ t[i];
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0]  eq;
    logic [NUM_OUT-1:0] em;
    logic [SW-1:0]      es;
    logic [SW-1:0]      pop;
    foreach (m_q[i]) eq[i] = m_q[i];
    for (int j = 0; j < NUM_OUT; j++) begin
      em[j] = m_mux[j];
      es[j*CNT_W +: CNT_W] = CNT_W'(m_snap[j]);
    end
    check("q", 128'(q), 128'(eq));
    check("mux_out", 128'(mux_out), 128'(em));
    check("snap_ack", 128'(snap_ack), 128'(m_ack));
    check("snap_cnt", 128'(snap_cnt), 128'(es));
    if (snap_ack) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 128'(1), 128'(0));
      end else begin
        pop = exp_q.pop_front();
        check("snap_sb", 128'(snap_cnt), 128'(pop));
      end
    end else if (exp_q.size() != 0) begin
      check("ack_missing", 128'(0), 128'(1));
      exp_q.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic c, input logic [NUM_CH-1:0] tv,
                       input logic [2:0] s, input logic sr);
    clr = c; t = tv; sel = s; snap_req = sr;
  endtask

  task automatic reset2();
    drive(1'b1, '0, 3'd0, 1'b0);
    tick(); tick();
  endtask

  logic [NUM_CH-1:0]  t0   = NUM_CH'(1);
  logic [NUM_CH-1:0]  tall = '1;
  logic [NUM_OUT-1:0] mall = '1;
  logic [NUM_OUT-1:0] held;
  logic [NUM_CH-1:0]  tr;

  initial begin
    // Reset and XOR
    reset2();
    check("rst_q", 128'(q), 128'(0));
    check("rst_mux", 128'(mux_out), 128'(0));
    check("rst_ack", 128'(snap_ack), 128'(0));
    check("rst_snap", 128'(snap_cnt), 128'(0));
    drive(1'b0, tall, 3'd0, 1'b0); tick();
    check("xor_q_all1", 128'(q), 128'(tall));
    drive(1'b0, '0, 3'd0, 1'b0); tick();
    check("xor_even_group", 128'(mux_out), 128'(0));
    check("xor_snap0", 128'(snap_cnt), 128'(0));

    // AND / OR / NAND sweep with only q[0] set
    reset2();
    drive(1'b0, t0, 3'd1, 1'b0); tick();
    drive(1'b0, '0, 3'd1, 1'b0); tick(); tick();
    check("and_mux", 128'(mux_out), 128'(0));
    drive(1'b0, '0, 3'd2, 1'b0); tick(); tick();
    check("or_mux", 128'(mux_out), 128'(1));
    drive(1'b0, '0, 3'd5, 1'b0); tick(); tick();
    check("nand_mux", 128'(mux_out), 128'(mall));

    // HOLD: settle NOR, snapshot to clear counters, then toggle under HOLD
    drive(1'b0, '0, 3'd6, 1'b0); tick(); tick();
    check("nor_mux", 128'(mux_out), 128'(mall & ~NUM_OUT'(1)));
    held = mux_out;
    drive(1'b0, '0, 3'd7, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, tall, 3'd7, 1'b0); tick();
      check("hold_mux", 128'(mux_out), 128'(held));
    end
    drive(1'b0, '0, 3'd7, 1'b1); tick();
    check("hold_ack", 128'(snap_ack), 128'(1));
    check("hold_cnt0", 128'(snap_cnt), 128'(0));

    // Snapshot counting
    reset2();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, t0, 3'd0, 1'b0); tick();
    end
    drive(1'b0, '0, 3'd0, 1'b1); tick();
    check("snap_ack1", 128'(snap_ack), 128'(1));
    check("snap_cnt10", 128'(snap_cnt), 128'(10));
    drive(1'b0, '0, 3'd0, 1'b0); tick();
    check("snap_ack_drop", 128'(snap_ack), 128'(0));
    check("snap_cnt_stable", 128'(snap_cnt), 128'(10));
    tick(); tick();
    drive(1'b0, '0, 3'd0, 1'b1); tick();
    check("snap2_ack", 128'(snap_ack), 128'(1));
    check("snap2_cnt0", 128'(snap_cnt), 128'(0));

    // Saturation
    reset2();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, t0, 3'd0, 1'b0); tick();
    end
    drive(1'b0, '0, 3'd0, 1'b1); tick();
    check("sat_cnt", 128'(snap_cnt), 128'(CMAX));

    // Back-to-back snapshots: held request gives consecutive acks
    drive(1'b0, t0, 3'd0, 1'b1); tick(); tick(); tick();
    check("b2b_ack", 128'(snap_ack), 128'(1));

    // Reset overlap
    for (int i = 0; i < 6; i++) begin
      foreach (tr[k]) tr[k] = 1'($urandom_range(0, 1));
      drive(1'b0, tr, 3'($urandom_range(0, 6)), 1'b0); tick();
    end
    drive(1'b1, tall, 3'd0, 1'b1); tick();
    check("ovl_ack", 128'(snap_ack), 128'(0));
    check("ovl_snap", 128'(snap_cnt), 128'(0));
    check("ovl_q", 128'(q), 128'(0));
    check("ovl_mux", 128'(mux_out), 128'(0));

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      foreach (tr[k]) tr[k] = ($urandom_range(0, 3) == 0);
      drive(($urandom_range(0, 49) == 0), tr, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0));
      tick();
    end

    drive(1'b0, '0, 3'd7, 1'b0); tick();
    check("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toggle_reduce_bank.md
# toggle_reduce_bank

Parametrised successor to the multi-channel toggle-flop/reduction test design used in the qlf_k4n8 clock-tree tests. It has the following parts:
- a bank of NUM_CH toggle flip-flops with per-channel toggle enables;
- per-group reduction under an 8-mode select, with a registered, holdable output;
- saturating per-output transition counters, read through a snapshot handshake.

Single clock domain. Intended as a dense, routable sequential load for fabric and clock-network tests with observable, self-checking activity.

## Interface
Parameters:
- NUM_CH, 80, number of toggle channels; must be a multiple of GROUP
- GROUP, 4, channels reduced into one output; ≥ 2
- CNT_W, 8, width of each transition counter
- NUM_OUT (derived, not overridable), NUM_CH/GROUP

Ports:
- clk  in  1  single clock, all state updates on posedge
- clr  in  1  reset; synchronous, active-high
- t  in  NUM_CH  per-channel toggle enable
- sel  in  3  reduction mode
- snap_req  in  1  snapshot request, sampled each posedge
- q  out  NUM_CH  toggle flop states
- mux_out  out  NUM_OUT  registered reduction results
- snap_ack  out  1  one-cycle snapshot acknowledge
- snap_cnt  out  NUM_OUT*CNT_W  captured counters; output j occupies bits [j*CNT_W +: CNT_W]

## Operation
Reset and priority:
- clr high at a posedge: q, mux_out, all live counters, snap_cnt and snap_ack go to 0.
- clr has priority over every other input.

Toggle bank:
- q[i] <= q[i] ^ t[i] each cycle.

Grouping:
- Output j reduces channels j*GROUP .. j*GROUP+GROUP-1 (contiguous).
- Let r_j be that reduction, computed combinationally from the current q.

Modes (sel):
- 0: XOR
- 1: AND
- 2: OR
- 3: constant 0
- 4: XNOR
- 5: NAND
- 6: NOR
- 7: HOLD, where mux_out keeps its value
- The next mux_out value is r_j, except in HOLD.

Live counters:
- There is one live counter cnt_j per output, CNT_W bits, not externally visible.
- On a posedge where the next mux_out[j] differs from the current mux_out[j], the counter candidate is cnt_j+1.
- The count saturates at 2^CNT_W-1 and never wraps.

Snapshot:
- If snap_req is high at a posedge, snap_cnt[j] <= counter candidate (this edge's transition included) and cnt_j <= 0.
- Otherwise cnt_j <= candidate and snap_cnt holds.
- snap_ack <= snap_req, so ack is registered and high for the cycle after each sampled request.
- snap_req held N cycles performs N snapshots and gives N consecutive ack cycles; each snapshot after the first captures only the transitions since the previous one.
- snap_req together with clr: clr wins, snap_cnt = 0 and snap_ack = 0.

Mode changes:
- A sel change takes effect at the next posedge.
- A mux_out transition caused by a sel change counts like any other transition.

## Timing
- t[i] high at edge k: q[i] flips at edge k, visible after k.
- mux_out reflects q one edge later: total t→mux_out latency is 2 clocks.
- Counter update happens on the same edge as the mux_out transition it counts.
- snap_req→snap_ack latency is 1 clock. snap_cnt is valid when snap_ack is high and stable until the next snapshot or clr.
- No combinational path from any input to any output; all outputs are flop-driven.
- Reset mid-operation: counters lose any pending increment, the snapshot is discarded, and the first post-reset cycle starts from all-zero state.

## Test plan
- Reset and XOR:
  - Stimulus: clr for 2 cycles, then sel=0, t all 1 for 1 cycle.
  - Required: q = all 1 after edge 1; mux_out = 0 after edge 2 (even GROUP XOR); all snap_cnt = 0.
- AND/OR/NAND sweep:
  - Stimulus: t[0]=1 once (q[0]=1, rest 0); step sel 1,2,5 with 2 cycles each.
  - Required: mux_out[0] = 0, then 1, then 1; mux_out[1..] = 0, 0, 1.
- HOLD:
  - Stimulus: sel=6 (NOR) to settle mux_out[1]=1; switch to sel=7; toggle all t for 5 cycles.
  - Required: mux_out unchanged throughout; counters do not increment.
- Snapshot counting:
  - Stimulus: sel=0, t[0]=1 continuously for 10 cycles, then 1-cycle snap_req.
  - Required: snap_ack high exactly one cycle later; snap_cnt[0] = 10 ±0 by exact model; other outputs 0; a second snap_req 3 idle cycles later gives snap_cnt[0] = 0.
- Saturation (CNT_W=4):
  - Stimulus: t[0]=1 for 40 cycles, then snap_req.
  - Required: snap_cnt[0] = 15.
- Reset overlap:
  - Stimulus: assert clr and snap_req on the same edge after activity.
  - Required: snap_ack = 0 next cycle; snap_cnt = 0; q and mux_out = 0.
